// File: rtl/mem_arb_pkg.sv
// Shared constants for the two-client memory arbiter and its round-robin picker.
package mem_arb_pkg;

    localparam int DEFAULT_ADDR_W = 28;
    localparam int DEFAULT_LINE_W = 128;

    typedef logic [1:0] arbState_t;

    localparam arbState_t IDLE   = 2'd0;
    localparam arbState_t I_BUSY = 2'd1;
    localparam arbState_t D_BUSY = 2'd2;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

endpackage

// File: rtl/arb_rr2.sv
// Two-input round-robin picker: on a tie, the client that was not granted last wins.
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic iReq_i,
    input  logic dReq_i,
    input  logic lastGrant_i,
    output logic grant_o
);

    // Pick the lone requester, or alternate against the previous winner on a tie
    always_comb begin
        grant_o = GRANT_I;
        if (iReq_i && dReq_i) begin
            grant_o = (lastGrant_i == GRANT_I) ? GRANT_D : GRANT_I;
        end else if (dReq_i) begin
            grant_o = GRANT_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Merges icache fills and dcache fills/write-backs onto one registered memory port,
// one transaction in flight at a time, returning ready only to the granted client.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int LINE_W = DEFAULT_LINE_W,
    parameter int POLICY = 0
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              i_mem_read,
    input  logic [ADDR_W-1:0] i_mem_addr,
    output logic [LINE_W-1:0] i_mem_rdata,
    output logic              i_mem_ready,
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_mem_addr,
    input  logic [LINE_W-1:0] d_mem_wdata,
    output logic [LINE_W-1:0] d_mem_rdata,
    output logic              d_mem_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready
`ifdef DEBUG_STAT
    ,
    output logic [31:0]       i_grant_count,
    output logic [31:0]       d_grant_count,
    output logic [31:0]       conflict_cycles
`endif
);

    arbState_t         state_q, state_d;
    logic              lastGrant_q, lastGrant_d;
    logic              memRead_q, memRead_d;
    logic              memWrite_q, memWrite_d;
    logic [ADDR_W-1:0] memAddr_q, memAddr_d;
    logic [LINE_W-1:0] memWdata_q, memWdata_d;

    logic iReq;
    logic dReq;
    logic rrGrant;
    logic winner;
    logic grantNow;

    assign iReq     = i_mem_read;
    assign dReq     = d_mem_read | d_mem_write;
    assign grantNow = (state_q == IDLE) && (iReq || dReq);

    arb_rr2 u_rr (
        .iReq_i      (iReq),
        .dReq_i      (dReq),
        .lastGrant_i (lastGrant_q),
        .grant_o     (rrGrant)
    );

    // Fixed-priority mode lets icache win any tie; otherwise defer to the round-robin pick
    always_comb begin
        winner = rrGrant;
        if (POLICY == 1) begin
            winner = iReq ? GRANT_I : GRANT_D;
        end
    end

    // Next-state: grant from IDLE and latch the winner's request, then hold until memory completes
    always_comb begin
        state_d     = state_q;
        lastGrant_d = lastGrant_q;
        memRead_d   = memRead_q;
        memWrite_d  = memWrite_q;
        memAddr_d   = memAddr_q;
        memWdata_d  = memWdata_q;
        case (state_q)
            IDLE: begin
                if (grantNow) begin
                    lastGrant_d = winner;
                    if (winner == GRANT_I) begin
                        state_d    = I_BUSY;
                        memRead_d  = 1'b1;
                        memWrite_d = 1'b0;
                        memAddr_d  = i_mem_addr;
                    end else begin
                        state_d    = D_BUSY;
                        memWrite_d = d_mem_write;
                        memRead_d  = ~d_mem_write;
                        memAddr_d  = d_mem_addr;
                        memWdata_d = d_mem_wdata;
                    end
                end
            end
            I_BUSY, D_BUSY: begin
                if (mem_ready) begin
                    state_d    = IDLE;
                    memRead_d  = 1'b0;
                    memWrite_d = 1'b0;
                end
            end
            default: begin
                state_d    = IDLE;
                memRead_d  = 1'b0;
                memWrite_d = 1'b0;
            end
        endcase
    end

    // State and memory-port registers; reset also aborts any transaction in flight
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state_q     <= IDLE;
            lastGrant_q <= GRANT_D;
            memRead_q   <= 1'b0;
            memWrite_q  <= 1'b0;
            memAddr_q   <= '0;
            memWdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            lastGrant_q <= lastGrant_d;
            memRead_q   <= memRead_d;
            memWrite_q  <= memWrite_d;
            memAddr_q   <= memAddr_d;
            memWdata_q  <= memWdata_d;
        end
    end

    assign mem_read    = memRead_q;
    assign mem_write   = memWrite_q;
    assign mem_addr    = memAddr_q;
    assign mem_wdata   = memWdata_q;
    assign i_mem_rdata = mem_rdata;
    assign d_mem_rdata = mem_rdata;
    assign i_mem_ready = (state_q == I_BUSY) && mem_ready && !proc_reset;
    assign d_mem_ready = (state_q == D_BUSY) && mem_ready && !proc_reset;

`ifdef DEBUG_STAT
    logic [31:0] iGrantCount_q;
    logic [31:0] dGrantCount_q;
    logic [31:0] conflictCycles_q;

    // Debug statistics: grants per client and cycles where both clients contend
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            iGrantCount_q    <= '0;
            dGrantCount_q    <= '0;
            conflictCycles_q <= '0;
        end else begin
            if (grantNow && (winner == GRANT_I)) begin
                iGrantCount_q <= iGrantCount_q + 32'd1;
            end
            if (grantNow && (winner == GRANT_D)) begin
                dGrantCount_q <= dGrantCount_q + 32'd1;
            end
            if (iReq && dReq) begin
                conflictCycles_q <= conflictCycles_q + 32'd1;
            end
        end
    end

    assign i_grant_count   = iGrantCount_q;
    assign d_grant_count   = dGrantCount_q;
    assign conflict_cycles = conflictCycles_q;
`endif

endmodule
